// File: rtl/vga_sync_gen_pkg.sv
// vga_pkg: shared 640x480@60 VGA timing constants and the coordinate type.
// Used by vga_sync_gen, its interface, and any pixel-side consumer that needs
// to know where the active area and sync pulses sit.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;  // 800

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;  // 525

  // Sync windows, both ends inclusive.
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FRONT;               // 656
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;        // 751
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FRONT;               // 490
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;        // 491

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: bundle between the sync generator and its consumers
// (pixel generator, DAC/pin stage).
//   pixelClockIn : divided 25 MHz square wave, sampled as data
//   pixelTick    : one-cycle strobe, aligned with the updated outputs
//   hSync/vSync  : active-low syncs
//   videoOn      : inside the visible area
//   pixelX/Y     : current raster position (not clamped in blanking)
//   frameStart   : one-cycle pulse when the raster enters (0,0)
// master = the generator, slave = a consumer that also supplies the divided clock.
interface vga_sync_gen_if;
  import vga_pkg::*;

  logic   pixelClockIn;
  logic   pixelTick;
  logic   hSync;
  logic   vSync;
  logic   videoOn;
  coord_t pixelX;
  coord_t pixelY;
  logic   frameStart;

  modport master (
    input  pixelClockIn,
    output pixelTick, hSync, vSync, videoOn, pixelX, pixelY, frameStart
  );

  modport slave (
    output pixelClockIn,
    input  pixelTick, hSync, vSync, videoOn, pixelX, pixelY, frameStart
  );

endinterface

// File: rtl/vga_sync_gen_tick.sv
// pixel_tick_detect: rising-edge strobe for a divided clock that lives as data
// in the clock50MHz domain.
//   clock50MHz   : system clock
//   inReset      : async active-high reset
//   pixelClockIn : divided clock, already synchronous to clock50MHz
//   tick         : combinational, high in the cycle a rise is seen
module pixel_tick_detect (
  input  logic clock50MHz,
  input  logic inReset,
  input  logic pixelClockIn,
  output logic tick
);

  logic prevIn;

  // prevIn resets high so a divider that is already high when reset drops
  // is not mistaken for a rise; the first genuine low->high edge is needed.
  always_ff @(posedge clock50MHz or posedge inReset) begin
    if (inReset) prevIn <= 1'b1;
    else         prevIn <= pixelClockIn;
  end

  assign tick = pixelClockIn & ~prevIn;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters and sync/blank decode for VGA timing, advanced
// once per pixel tick derived from the divided clock.
//   clock50MHz : only clock
//   inReset    : async active-high reset
//   vga        : master side of vga_sync_gen_if (pixelClockIn in, timing out)
// Timing defaults to 640x480@60; the parameters allow reduced rasters.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT = H_ACTIVE,
  parameter int unsigned H_FP  = H_FRONT,
  parameter int unsigned H_SW  = H_SYNC,
  parameter int unsigned H_BP  = H_BACK,
  parameter int unsigned V_ACT = V_ACTIVE,
  parameter int unsigned V_FP  = V_FRONT,
  parameter int unsigned V_SW  = V_SYNC,
  parameter int unsigned V_BP  = V_BACK
) (
  input  logic       clock50MHz,
  input  logic       inReset,
  vga_sync_gen_if.master vga
);

  localparam coord_t H_LAST   = coord_t'(H_ACT + H_FP + H_SW + H_BP - 1);
  localparam coord_t V_LAST   = coord_t'(V_ACT + V_FP + V_SW + V_BP - 1);
  localparam coord_t H_VIS    = coord_t'(H_ACT);
  localparam coord_t V_VIS    = coord_t'(V_ACT);
  localparam coord_t HS_FIRST = coord_t'(H_ACT + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_ACT + H_FP + H_SW - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACT + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_ACT + V_FP + V_SW - 1);

  logic   tick;
  logic   hWrap;
  coord_t hCount, vCount;
  coord_t hNext, vNext;

  logic   pixelTickR, hSyncR, vSyncR, videoOnR, frameStartR;
  coord_t pixelXR, pixelYR;

  pixel_tick_detect uTick (
    .clock50MHz  (clock50MHz),
    .inReset     (inReset),
    .pixelClockIn(vga.pixelClockIn),
    .tick        (tick)
  );

  always_comb begin
    hWrap = (hCount == H_LAST);
    hNext = hWrap ? '0 : hCount + 1'b1;
    vNext = vCount;
    if (hWrap) vNext = (vCount == V_LAST) ? '0 : vCount + 1'b1;
  end

  // Counters start on the last position so the first tick lands on (0,0).
  // Outputs decode the next counts, so they line up with pixelTick.
  always_ff @(posedge clock50MHz or posedge inReset) begin
    if (inReset) begin
      hCount      <= H_LAST;
      vCount      <= V_LAST;
      pixelTickR  <= 1'b0;
      hSyncR      <= 1'b1;
      vSyncR      <= 1'b1;
      videoOnR    <= 1'b0;
      pixelXR     <= '0;
      pixelYR     <= '0;
      frameStartR <= 1'b0;
    end else begin
      pixelTickR  <= tick;
      frameStartR <= tick && (hNext == '0) && (vNext == '0);
      if (tick) begin
        hCount   <= hNext;
        vCount   <= vNext;
        hSyncR   <= !((hNext >= HS_FIRST) && (hNext <= HS_LAST));
        vSyncR   <= !((vNext >= VS_FIRST) && (vNext <= VS_LAST));
        videoOnR <= (hNext < H_VIS) && (vNext < V_VIS);
        pixelXR  <= hNext;
        pixelYR  <= vNext;
      end
    end
  end

  assign vga.pixelTick  = pixelTickR;
  assign vga.hSync      = hSyncR;
  assign vga.vSync      = vSyncR;
  assign vga.videoOn    = videoOnR;
  assign vga.pixelX     = pixelXR;
  assign vga.pixelY     = pixelYR;
  assign vga.frameStart = frameStartR;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;
  import vga_pkg::*;

  logic clk;
  logic rst;
  logic pin;

  int nTests = 0;
  int nFail  = 0;

  vga_sync_gen_if vifMain ();
  vga_sync_gen_if vifSmall ();
  assign vifMain.pixelClockIn  = pin;
  assign vifSmall.pixelClockIn = pin;

  vga_sync_gen dutMain (
    .clock50MHz(clk),
    .inReset   (rst),
    .vga       (vifMain)
  );

  // Reduced raster (15x13) so whole frames fit in a short run.
  vga_sync_gen #(
    .H_ACT(8), .H_FP(2), .H_SW(3), .H_BP(2),
    .V_ACT(6), .V_FP(2), .V_SW(2), .V_BP(3)
  ) dutSmall (
    .clock50MHz(clk),
    .inReset   (rst),
    .vga       (vifSmall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // kM = number of pixel ticks since reset; raster position after k ticks
  // is linear index (k-1) modulo frame size.
  int   kM;
  logic prevM, tickM;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      kM <= 0; prevM <= 1'b1; tickM <= 1'b0;
    end else begin
      tickM <= pin & ~prevM;
      prevM <= pin;
      if (pin & ~prevM) kM <= kM + 1;
    end
  end

  typedef struct {
    logic tk, hs, vs, von, fs;
    int   x, y;
  } exp_t;

  function automatic exp_t model(int k, logic tk, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb);
    exp_t e;
    int ht, vt, p;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    e.tk = tk;
    if (k == 0) begin
      e.hs = 1; e.vs = 1; e.von = 0; e.fs = 0; e.x = 0; e.y = 0;
    end else begin
      p    = (k - 1) % (ht * vt);
      e.x  = p % ht;
      e.y  = p / ht;
      e.hs = !(e.x >= ha + hf && e.x < ha + hf + hsw);
      e.vs = !(e.y >= va + vf && e.y < va + vf + vsw);
      e.von = (e.x < ha) && (e.y < va);
      e.fs = tk && (p == 0);
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input logic tk, hs, vs, von, fs,
                     input int x, input int y, input exp_t e);
    nTests++;
    if (tk !== e.tk || hs !== e.hs || vs !== e.vs || von !== e.von || fs !== e.fs ||
        x != e.x || y != e.y) begin
      nFail++;
      $display("FAIL %s t=%0t got tick=%b hs=%b vs=%b von=%b fs=%b x=%0d y=%0d want tick=%b hs=%b vs=%b von=%b fs=%b x=%0d y=%0d",
               nm, $time, tk, hs, vs, von, fs, x, y, e.tk, e.hs, e.vs, e.von, e.fs, e.x, e.y);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, both instances.
  always @(negedge clk) begin
    exp_t eM, eS;
    eM = model(kM, tickM, 640, 16, 96, 48, 480, 10, 2, 33);
    eS = model(kM, tickM, 8, 2, 3, 2, 6, 2, 2, 3);
    cmp("main", vifMain.pixelTick, vifMain.hSync, vifMain.vSync, vifMain.videoOn,
        vifMain.frameStart, int'(vifMain.pixelX), int'(vifMain.pixelY), eM);
    cmp("small", vifSmall.pixelTick, vifSmall.hSync, vifSmall.vSync, vifSmall.videoOn,
        vifSmall.frameStart, int'(vifSmall.pixelX), int'(vifSmall.pixelY), eS);
  end

  // Hand-computed edge expectations, independent of the model.
  always @(negedge clk) begin
    if (!rst && vifMain.pixelTick) begin
      case (int'(vifMain.pixelX))
        655: chk("hsync_655", vifMain.hSync, 1);
        656: chk("hsync_656", vifMain.hSync, 0);
        751: chk("hsync_751", vifMain.hSync, 0);
        752: chk("hsync_752", vifMain.hSync, 1);
        639: chk("von_639", vifMain.videoOn, 1);
        640: chk("von_640", vifMain.videoOn, 0);
        default: ;
      endcase
      if (kM == 800) chk("x_799_y0", int'(vifMain.pixelY) * 1000 + int'(vifMain.pixelX), 799);
      if (kM == 801) chk("wrap_y1", int'(vifMain.pixelY) * 1000 + int'(vifMain.pixelX), 1000);
    end
    if (!rst && vifSmall.pixelTick) begin
      case (int'(vifSmall.pixelY))
        7:  chk("s_vsync_7", vifSmall.vSync, 1);
        8:  chk("s_vsync_8", vifSmall.vSync, 0);
        9:  chk("s_vsync_9", vifSmall.vSync, 0);
        10: chk("s_vsync_10", vifSmall.vSync, 1);
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v);
    @(posedge clk);
    #1 pin = v;
  endtask

  task automatic stepRand();
    step(($urandom_range(0, 9) == 0) ? pin : ~pin);
  endtask

  task automatic chkResetVals(input string nm, input logic tk, hs, vs, von, fs,
                              input int x, input int y);
    chk({nm, "_tick"}, tk, 0);
    chk({nm, "_hs"}, hs, 1);
    chk({nm, "_vs"}, vs, 1);
    chk({nm, "_von"}, von, 0);
    chk({nm, "_fs"}, fs, 0);
    chk({nm, "_xy"}, x * 1000 + y, 0);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    pin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chkResetVals("rst0", vifMain.pixelTick, vifMain.hSync, vifMain.vSync, vifMain.videoOn,
                 vifMain.frameStart, int'(vifMain.pixelX), int'(vifMain.pixelY));

    // First rise lands on (0,0) with frameStart.
    step(1'b1);
    step(1'b0);
    chk("first_tick", vifMain.pixelTick, 1);
    chk("first_xy", int'(vifMain.pixelX) * 1000 + int'(vifMain.pixelY), 0);
    chk("first_von", vifMain.videoOn, 1);
    chk("first_fs", vifMain.frameStart, 1);
    step(1'b1);
    chk("fs_clear", vifMain.frameStart, 0);
    chk("tick_clear", vifMain.pixelTick, 0);
    repeat (20) step(~pin);

    // Divider high through reset release: no tick until a real rise.
    pin = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) step(1'b1);
    chkResetVals("hold1", vifMain.pixelTick, vifMain.hSync, vifMain.vSync, vifMain.videoOn,
                 vifMain.frameStart, int'(vifMain.pixelX), int'(vifMain.pixelY));
    step(1'b0);
    step(1'b1);
    step(1'b0);
    chk("hold1_fs", vifMain.frameStart, 1);

    // Random divider until pixelX = 300, then stall high.
    guard = 0;
    while (kM != 301 && guard < 3000) begin stepRand(); guard++; end
    chk("reach_x300", kM, 301);
    pin = 1'b1;
    repeat (50) step(1'b1);
    chk("stall_x", int'(vifMain.pixelX), 300);
    chk("stall_tick", vifMain.pixelTick, 0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    chk("after_stall_x", int'(vifMain.pixelX), 301);

    // Second line, pixelX = 700: async reset between edges.
    guard = 0;
    while (kM != 1501 && guard < 6000) begin stepRand(); guard++; end
    chk("reach_x700", kM, 1501);
    chk("pre_rst_hs", vifMain.hSync, 0);
    #1 rst = 1'b1;
    #1;
    chkResetVals("async_main", vifMain.pixelTick, vifMain.hSync, vifMain.vSync, vifMain.videoOn,
                 vifMain.frameStart, int'(vifMain.pixelX), int'(vifMain.pixelY));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    pin = 1'b0;
    step(1'b1);
    step(1'b0);
    chk("rst_main_fs", vifMain.frameStart, 1);
    chk("rst_main_xy", int'(vifMain.pixelX) * 1000 + int'(vifMain.pixelY), 0);

    // Small raster: reset while vSync is low (y=9, x=5).
    guard = 0;
    while (!(kM > 0 && (kM - 1) % 195 == 140) && guard < 1500) begin stepRand(); guard++; end
    chk("reach_small_vs", (kM - 1) % 195, 140);
    chk("pre_rst_vs", vifSmall.vSync, 0);
    #1 rst = 1'b1;
    #1;
    chkResetVals("async_small", vifSmall.pixelTick, vifSmall.hSync, vifSmall.vSync,
                 vifSmall.videoOn, vifSmall.frameStart, int'(vifSmall.pixelX), int'(vifSmall.pixelY));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pin = 1'b0;
    step(1'b1);
    step(1'b0);
    chk("rst_small_fs", vifSmall.frameStart, 1);

    // Free run across several small frames.
    repeat (2000) stepRand();

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
